cpu_data_mc: RTL

Parametrised, multi-cycle successor of the accumulator datapath. It contains a register file, accumulator, ALU and C/Z/B flag register. Data memory is external, reached through a req/ack handshake with wait states and a timeout. Operations arrive from the control unit via a valid/ready handshake. Non-memory ops complete in one cycle; memory ops stall until acknowledged.

---
 rtl/cpu_data_pkg.sv | 31 +++
 rtl/cpu_data_alu.sv | 80 ++++++++
 rtl/cpu_data_mc.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_data_pkg.sv
// cpu_data_pkg: shared constants for the multi-cycle accumulator datapath.
// Holds ALU opcodes, ALU operand-B source encodings and the control FSM states.
package cpu_data_pkg;

  // ALU operation codes; 12..15 are NOPs (result = A, flags untouched)
  localparam logic [3:0] OP_PASSB = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADC   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_SBB   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_NOT   = 4'd8;
  localparam logic [3:0] OP_SHL   = 4'd9;
  localparam logic [3:0] OP_SHR   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  // ALU operand-B sources; bit 1 set means the operand comes from memory
  localparam logic [1:0] SRC_B_IMM  = 2'd0;
  localparam logic [1:0] SRC_B_REG  = 2'd1;
  localparam logic [1:0] SRC_B_MEM0 = 2'd2;
  localparam logic [1:0] SRC_B_MEM1 = 2'd3;

  // Control FSM states
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/cpu_data_alu.sv
// cpu_data_alu: purely combinational ALU of the accumulator datapath.
// Optional multiply (op 11) is built only when CPU_DATA_MUL_EN is defined;
// otherwise op 11 behaves as a pass-through of A (the top flags it illegal).
module cpu_data_alu
  import cpu_data_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  input  logic             bin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             bout
);

  logic [WIDTH:0] sum_s;
`ifdef CPU_DATA_MUL_EN
  logic [2*WIDTH-1:0] prod_s;
`endif

  // Operation decode; the extra sum bit is carry for add and borrow for subtract
  always_comb begin
    result = a;
    cout   = cin;
    bout   = bin;
    sum_s  = {(WIDTH+1){1'b0}};
`ifdef CPU_DATA_MUL_EN
    prod_s = {(2*WIDTH){1'b0}};
`endif
    case (op)
      OP_PASSB: result = b;
      OP_ADD: begin
        sum_s  = {1'b0, a} + {1'b0, b};
        result = sum_s[WIDTH-1:0];
        cout   = sum_s[WIDTH];
      end
      OP_ADC: begin
        sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        result = sum_s[WIDTH-1:0];
        cout   = sum_s[WIDTH];
      end
      OP_SUB: begin
        sum_s  = {1'b0, a} - {1'b0, b};
        result = sum_s[WIDTH-1:0];
        bout   = sum_s[WIDTH];
      end
      OP_SBB: begin
        sum_s  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        result = sum_s[WIDTH-1:0];
        bout   = sum_s[WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        cout   = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        cout   = a[0];
      end
      OP_MUL: begin
`ifdef CPU_DATA_MUL_EN
        prod_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        result = prod_s[WIDTH-1:0];
        cout   = |prod_s[2*WIDTH-1:WIDTH];
`else
        result = a;
`endif
      end
      default: result = a;
    endcase
  end

endmodule

// File: rtl/cpu_data_mc.sv
// cpu_data_mc: multi-cycle accumulator datapath with register file, C/Z/B
// flags and an external data memory reached via req/ack with timeout.
// Configuration macro: CPU_DATA_MUL_EN enables op 11 as unsigned multiply;
// without it op 11 is rejected with an ERR pulse.
module cpu_data_mc
  import cpu_data_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NREGS       = 9,
  parameter int AWIDTH      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     OP_VALID,
  output logic                     OP_READY,
  input  logic [3:0]               ALU_OP,
  input  logic [1:0]               SRC_B_SEL,
  input  logic [$clog2(NREGS)-1:0] REG_SEL,
  input  logic [WIDTH-1:0]         IMM,
  input  logic                     ADDR_MODE,
  input  logic                     EN_ACC,
  input  logic                     EN_REG_F,
  input  logic                     EN_D_MEM,
  output logic                     MEM_REQ,
  output logic                     MEM_WE,
  output logic [AWIDTH-1:0]        MEM_ADDR,
  output logic [WIDTH-1:0]         MEM_WDATA,
  input  logic [WIDTH-1:0]         MEM_RDATA,
  input  logic                     MEM_ACK,
  output logic [WIDTH-1:0]         ACC,
  output logic [WIDTH-1:0]         PORT_OUT,
  output logic                     C,
  output logic                     Z,
  output logic                     B,
  output logic                     ERR
);

  localparam int RSW = $clog2(NREGS);
  localparam int CW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RSW-1:0] LAST_REG = RSW'(NREGS - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_e              state_r, next_s;
  logic [CW-1:0]       cnt_r;
  logic                op_ready_r, mem_req_r, mem_we_r, err_r;
  logic [AWIDTH-1:0]   mem_addr_r;
  logic [WIDTH-1:0]    mem_wdata_r, acc_r;
  logic                c_r, z_r, b_r;
  logic [WIDTH-1:0]    regf_r [NREGS];

  // Op fields captured while a memory access is outstanding
  logic [3:0]          op_r;
  logic [1:0]          srcb_r;
  logic [RSW-1:0]      sel_r;
  logic [WIDTH-1:0]    imm_r;
  logic                en_acc_r, en_reg_r, both_r;

  logic [3:0]          cur_op_s;
  logic [1:0]          cur_srcb_s;
  logic [RSW-1:0]      cur_sel_s;
  logic [WIDTH-1:0]    cur_imm_s, reg_rd_s, b_val_s, alu_res_s;
  logic                cur_en_acc_s, cur_en_reg_s;
  logic [AWIDTH-1:0]   addr_s;
  logic                alu_c_s, alu_b_s, c_upd_s, b_upd_s, z_upd_s;
  logic                mem_op_in_s, both_in_s, mul_ill_s;
  logic                start_mem_s, mem_done_s, commit_s, err_s;

  assign OP_READY  = op_ready_r;
  assign MEM_REQ   = mem_req_r;
  assign MEM_WE    = mem_we_r;
  assign MEM_ADDR  = mem_addr_r;
  assign MEM_WDATA = mem_wdata_r;
  assign ACC       = acc_r;
  assign C         = c_r;
  assign Z         = z_r;
  assign B         = b_r;
  assign ERR       = err_r;
  assign PORT_OUT  = regf_r[NREGS-1];

  assign mem_op_in_s = EN_D_MEM | SRC_B_SEL[1];
  assign both_in_s   = EN_D_MEM & SRC_B_SEL[1];
`ifdef CPU_DATA_MUL_EN
  assign mul_ill_s   = 1'b0;
`else
  assign mul_ill_s   = (ALU_OP == OP_MUL);
`endif

  // Live op fields in IDLE, captured fields while waiting on memory
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_op_s     = ALU_OP;
      cur_srcb_s   = SRC_B_SEL;
      cur_sel_s    = REG_SEL;
      cur_imm_s    = IMM;
      cur_en_acc_s = EN_ACC;
      cur_en_reg_s = EN_REG_F;
    end else begin
      cur_op_s     = op_r;
      cur_srcb_s   = srcb_r;
      cur_sel_s    = sel_r;
      cur_imm_s    = imm_r;
      cur_en_acc_s = en_acc_r;
      cur_en_reg_s = en_reg_r;
    end
  end

  // Register read (out-of-range index reads zero), operand B and address select
  always_comb begin
    if (cur_sel_s <= LAST_REG) begin
      reg_rd_s = regf_r[cur_sel_s];
    end else begin
      reg_rd_s = {WIDTH{1'b0}};
    end
    case (cur_srcb_s)
      SRC_B_IMM:  b_val_s = cur_imm_s;
      SRC_B_REG:  b_val_s = reg_rd_s;
      SRC_B_MEM0: b_val_s = MEM_RDATA;
      SRC_B_MEM1: b_val_s = MEM_RDATA;
      default:    b_val_s = MEM_RDATA;
    endcase
    if (ADDR_MODE) begin
      addr_s = AWIDTH'(reg_rd_s);
    end else begin
      addr_s = AWIDTH'(IMM);
    end
  end

  cpu_data_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (acc_r),
    .b      (b_val_s),
    .op     (cur_op_s),
    .cin    (c_r),
    .bin    (b_r),
    .result (alu_res_s),
    .cout   (alu_c_s),
    .bout   (alu_b_s)
  );

  // Which flags an op is allowed to touch; NOPs leave even Z alone
  always_comb begin
    c_upd_s = 1'b0;
    b_upd_s = 1'b0;
    z_upd_s = (cur_op_s <= OP_MUL);
    case (cur_op_s)
      OP_ADD, OP_ADC, OP_SHL, OP_SHR: c_upd_s = 1'b1;
`ifdef CPU_DATA_MUL_EN
      OP_MUL: c_upd_s = 1'b1;
`endif
      OP_SUB, OP_SBB: b_upd_s = 1'b1;
      default: c_upd_s = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next state plus commit/error decisions for the current cycle
  always_comb begin
    next_s      = state_r;
    start_mem_s = 1'b0;
    mem_done_s  = 1'b0;
    commit_s    = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (OP_VALID) begin
          if (mul_ill_s) begin
            err_s = 1'b1;
          end else if (mem_op_in_s) begin
            start_mem_s = 1'b1;
            next_s      = ST_MEM_WAIT;
          end else begin
            commit_s = 1'b1;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        if (MEM_ACK) begin
          mem_done_s = 1'b1;
          next_s     = ST_IDLE;
          if (both_r) begin
            err_s = 1'b1;
          end else begin
            commit_s = 1'b1;
          end
        end else if (cnt_r == CNT_LAST) begin
          mem_done_s = 1'b1;
          err_s      = 1'b1;
          next_s     = ST_IDLE;
        end else begin
          next_s = ST_MEM_WAIT;
        end
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // Memory interface, op capture, wait counter and handshake outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_ready_r  <= 1'b1;
      err_r       <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AWIDTH{1'b0}};
      mem_wdata_r <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      op_r        <= 4'd0;
      srcb_r      <= 2'd0;
      sel_r       <= {RSW{1'b0}};
      imm_r       <= {WIDTH{1'b0}};
      en_acc_r    <= 1'b0;
      en_reg_r    <= 1'b0;
      both_r      <= 1'b0;
    end else begin
      op_ready_r <= (next_s == ST_IDLE);
      err_r      <= err_s;
      if (start_mem_s) begin
        mem_req_r   <= 1'b1;
        mem_we_r    <= EN_D_MEM;
        mem_addr_r  <= addr_s;
        mem_wdata_r <= acc_r;
        cnt_r       <= {CW{1'b0}};
        op_r        <= ALU_OP;
        srcb_r      <= SRC_B_SEL;
        sel_r       <= REG_SEL;
        imm_r       <= IMM;
        en_acc_r    <= EN_ACC;
        en_reg_r    <= EN_REG_F;
        both_r      <= both_in_s;
      end else if (mem_done_s) begin
        mem_req_r <= 1'b0;
        cnt_r     <= {CW{1'b0}};
      end else if (state_r == ST_MEM_WAIT) begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end
  end

  // Architectural state: register file gets pre-op ACC, ACC/flags get ALU result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_r <= {WIDTH{1'b0}};
      c_r   <= 1'b0;
      z_r   <= 1'b0;
      b_r   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regf_r[i] <= {WIDTH{1'b0}};
      end
    end else if (commit_s) begin
      if (cur_en_reg_s && (cur_sel_s <= LAST_REG)) begin
        regf_r[cur_sel_s] <= acc_r;
      end
      if (cur_en_acc_s) begin
        acc_r <= alu_res_s;
        if (c_upd_s) c_r <= alu_c_s;
        if (b_upd_s) b_r <= alu_b_s;
        if (z_upd_s) z_r <= (alu_res_s == {WIDTH{1'b0}});
      end
    end
  end

endmodule
